msk_encoder: RTL and testbench
==============================

# msk_encoder

Masking encoder. It turns an unmasked `count`-bit value plus fresh randomness into a `d`-share Boolean sharing, using the same bit/share layout that the sharewise gadgets consume. It sits at the entry of the masked datapath and is the producing end of the sharing interface. It has valid/ready handshakes on the data, randomness and output sides, and a one-entry registered output, so no combinational logic sits between the unmasked data and the output shares.

## Interface
Parameters:
- `d`, default `DEFAULTSHARES` (2): number of shares, ≥2.
- `count`, default 1: number of independent bits encoded per transfer.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_data` in `count`: unmasked value.
- `in_valid` in 1 / `in_ready` out 1: data handshake.
- `rnd` in `count*(d-1)`: fresh randomness. Bit `rnd[i*(d-1)+k]` is random share k of bit i.
- `rnd_valid` in 1 / `rnd_ready` out 1: randomness handshake.
- `out_sh` out `count*d`: sharing. Bit `out_sh[i*d+j]` is share j of bit i.
- `out_valid` out 1 / `out_ready` in 1: output handshake.

## Operation
- `slot_free = !out_valid || out_ready`.
- `in_ready = slot_free && rnd_valid`.
- `rnd_ready = slot_free && in_valid`.
- Neither ready depends on its own valid, so there is no combinational loop.
- Encode event: `in_valid && rnd_valid && slot_free`. Data and randomness are always consumed together; neither is consumed alone.
- On an encode event, for each bit i:
  - shares j < d-1 take `rnd[i*(d-1)+j]`;
  - share d-1 takes `in_data[i]` XOR all `d-1` random shares of bit i.
- `out_valid` set on an encode event.
- `out_valid` cleared when `out_ready && out_valid` and there is no encode event in the same cycle.
- Simultaneous drain and encode: the new sharing replaces the old one, `out_valid` stays 1, and throughput is 1 per cycle.
- `out_sh` holds its value while `out_valid && !out_ready`, even if inputs change.
- Randomness is never reused: each accepted `rnd` word feeds exactly one sharing.

## Timing
- Latency: 1 cycle. A sharing accepted at edge n is visible on `out_sh` with `out_valid=1` after edge n.
- Full throughput: one encode per cycle when all valids and `out_ready` are high.
- Reset, asynchronous on `rst_n` low:
  - `out_valid=0` and `out_sh=0` immediately;
  - `in_ready=rnd_ready=0` while held.
- Reset mid-transfer: the held sharing is discarded, with no partial state.
- After `rst_n` rises, the first encode can occur on the next edge.
- Backpressure: with `out_valid=1` and `out_ready=0`, `in_ready=rnd_ready=0` regardless of the input valids.

## Configuration
- Macro: `MSK_ENC_ZEROIZE_EN`.
- Defined: when a sharing is drained without a simultaneous encode, `out_sh` is cleared to all zeros on the same edge that clears `out_valid`. No stale shares stay on the bus.
- Undefined: `out_sh` keeps the last sharing after draining, which saves the enable/clear muxing.
- Handshake behaviour is identical in both cases.

## Structure
- Shared package `msk_pkg`:
  - layout index functions `sh_idx(i,j)=i*d+j` and `rnd_idx(i,k)=i*(d-1)+k`;
  - the default share count constant.
- Sub-module `msk_enc_last_share` (params `d`, `count`): purely combinational XOR of `in_data` with the `d-1` random shares of each bit, giving `count` bits.
- Top module: handshake logic, output register, and zeroize option.

## Test plan
- d=2, count=4: `in_data=4'b1010`, `rnd=4'b0110`, both valid, `out_ready=1` → after 1 edge, `out_valid=1` and `out_sh=8'hB4`.
- d=3, count=1: 100 random `in_data`/`rnd` pairs → XOR of the 3 shares equals `in_data` every time, and shares 0–1 equal `rnd` exactly.
- Backpressure: hold `out_ready=0` for 5 cycles with valids high → `out_sh` stable, `in_ready=rnd_ready=0`, and no randomness consumed (count rnd handshakes = 1).
- Mismatched valids: `in_valid=1`, `rnd_valid=0` for 3 cycles → `in_ready=0`, `rnd_ready=1`, no transfer; raising `rnd_valid` → exactly one encode.
- Streaming: 16 back-to-back transfers with `out_ready=1` → 16 consecutive cycles with `out_valid=1` and no bubbles.
- Reset: assert `rst_n=0` between edges while `out_valid=1` → `out_valid=0` and `out_sh=0` immediately. With `MSK_ENC_ZEROIZE_EN`, draining without a new encode → `out_sh=0`.

Source files
------------

// File: rtl/msk_pkg.sv
// Shared masking package: share-layout index helpers and defaults.
// Bit i, share j of a sharing lives at i*d+j; random share k at i*(d-1)+k.
package msk_pkg;

    localparam int DEFAULTSHARES = 2;

    function automatic int sh_idx(input int i, input int j, input int d);
        return i * d + j;
    endfunction

    function automatic int rnd_idx(input int i, input int k, input int d);
        return i * (d - 1) + k;
    endfunction

endpackage

// File: rtl/msk_enc_last_share.sv
// Last-share generator: each data bit XORed with its d-1 random shares.
// Purely combinational; feeds the output register of msk_encoder.
module msk_enc_last_share
    import msk_pkg::*;
#(
    parameter int d     = DEFAULTSHARES,
    parameter int count = 1
) (
    input  logic [count-1:0]       in_data_i,
    input  logic [count*(d-1)-1:0] rnd_i,
    output logic [count-1:0]       last_o
);

    always_comb begin
        last_o = in_data_i;
        for (int i = 0; i < count; i++) begin
            for (int k = 0; k < d - 1; k++) begin
                last_o[i] = last_o[i] ^ rnd_i[rnd_idx(i, k, d)];
            end
        end
    end

endmodule

// File: rtl/msk_encoder.sv
// Masking encoder: unmasked data + fresh randomness -> registered d-share sharing.
// Define MSK_ENC_ZEROIZE_EN to clear out_sh when a sharing drains without refill.
module msk_encoder
    import msk_pkg::*;
#(
    parameter int d     = DEFAULTSHARES,
    parameter int count = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [count-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [count*(d-1)-1:0] rnd,
    input  logic                   rnd_valid,
    output logic                   rnd_ready,
    output logic [count*d-1:0]     out_sh,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic                 valid_q, valid_d;
    logic [count*d-1:0]   sh_q, sh_d;
    logic [count*d-1:0]   enc_sh;
    logic [count-1:0]     last_sh;
    logic                 slot_free;
    logic                 enc;

    msk_enc_last_share #(
        .d     (d),
        .count (count)
    ) u_last (
        .in_data_i (in_data),
        .rnd_i     (rnd),
        .last_o    (last_sh)
    );

    // Readies are held low while reset is asserted.
    assign slot_free = rst_n && (!valid_q || out_ready);
    assign in_ready  = slot_free && rnd_valid;
    assign rnd_ready = slot_free && in_valid;
    assign enc       = slot_free && in_valid && rnd_valid;

    always_comb begin
        enc_sh = '0;
        for (int i = 0; i < count; i++) begin
            for (int j = 0; j < d - 1; j++) begin
                enc_sh[sh_idx(i, j, d)] = rnd[rnd_idx(i, j, d)];
            end
            enc_sh[sh_idx(i, d - 1, d)] = last_sh[i];
        end
    end

    always_comb begin
        valid_d = valid_q;
        sh_d    = sh_q;
        if (enc) begin
            valid_d = 1'b1;
            sh_d    = enc_sh;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
`ifdef MSK_ENC_ZEROIZE_EN
            sh_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sh_q    <= '0;
        end else begin
            valid_q <= valid_d;
            sh_q    <= sh_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sh    = sh_q;

endmodule

// File: tb/tb_msk_encoder.sv
// Testbench for msk_encoder: d=2/count=4 and d=3/count=1 instances.
// Table vectors, handshake corner cases and random model checks.
module tb_msk_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // d=2, count=4 instance
    logic [3:0] a_data, a_rnd;
    logic       a_iv, a_rv, a_ir, a_rr, a_ov, a_or;
    logic [7:0] a_sh;

    // d=3, count=1 instance
    logic [0:0] b_data;
    logic [1:0] b_rnd;
    logic       b_iv, b_rv, b_ir, b_rr, b_ov, b_or;
    logic [2:0] b_sh;

    msk_encoder #(.d(2), .count(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_data), .in_valid(a_iv), .in_ready(a_ir),
        .rnd(a_rnd), .rnd_valid(a_rv), .rnd_ready(a_rr),
        .out_sh(a_sh), .out_valid(a_ov), .out_ready(a_or)
    );

    msk_encoder #(.d(3), .count(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_data), .in_valid(b_iv), .in_ready(b_ir),
        .rnd(b_rnd), .rnd_valid(b_rv), .rnd_ready(b_rr),
        .out_sh(b_sh), .out_valid(b_ov), .out_ready(b_or)
    );

    int n_chk = 0;
    int n_fail = 0;
    int a_hs = 0;

    always @(posedge clk) begin
        if (a_rv && a_rr) a_hs <= a_hs + 1;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference sharing for d=2,count=4: share 0 is the random bit,
    // share 1 makes the two shares XOR to the data bit.
    function automatic logic [7:0] ref_a(input logic [3:0] dat,
                                         input logic [3:0] r);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[2*i]   = r[i];
            s[2*i+1] = dat[i] ^ r[i];
        end
        return s;
    endfunction

    typedef struct {
        logic [3:0] data;
        logic [3:0] rnd;
        logic [7:0] sh;
    } vec_t;

    vec_t tbl[6];
    logic [7:0] exp_sh;
    logic [7:0] held;
    int hs0;

    initial begin
        tbl[0] = '{4'b1010, 4'b0110, 8'hB4};
        tbl[1] = '{4'b0000, 4'b0000, 8'h00};
        tbl[2] = '{4'b1111, 4'b0000, 8'hAA};
        tbl[3] = '{4'b0000, 4'b1111, 8'hFF};
        tbl[4] = '{4'b1111, 4'b1111, 8'h55};
        tbl[5] = '{4'b0101, 4'b0011, 8'h2D};

        a_data = '0; a_rnd = '0; a_iv = 1'b1; a_rv = 1'b1; a_or = 1'b1;
        b_data = '0; b_rnd = '0; b_iv = 1'b0; b_rv = 1'b0; b_or = 1'b1;

        #2;
        check("rst_out_valid", a_ov, 0);
        check("rst_out_sh", a_sh, 0);
        check("rst_in_ready", a_ir, 0);
        check("rst_rnd_ready", a_rr, 0);
        check("rst_b_out_valid", b_ov, 0);
        step();
        check("rst_held_no_encode", a_ov, 0);
        a_iv = 1'b0; a_rv = 1'b0;
        #2 rst_n = 1'b1;
        step();

        // Table vectors, back-to-back
        for (int k = 0; k < 6; k++) begin
            a_data = tbl[k].data; a_rnd = tbl[k].rnd;
            a_iv = 1'b1; a_rv = 1'b1; a_or = 1'b1;
            step();
            check($sformatf("tbl%0d_valid", k), a_ov, 1);
            check($sformatf("tbl%0d_sh", k), a_sh, tbl[k].sh);
        end
        a_iv = 1'b0; a_rv = 1'b0;
        step();
        check("drain_valid", a_ov, 0);
`ifdef MSK_ENC_ZEROIZE_EN
        check("drain_zeroize", a_sh, 0);
`else
        check("drain_hold", a_sh, tbl[5].sh);
`endif

        // Backpressure
        a_or = 1'b0;
        a_data = 4'b1010; a_rnd = 4'b0110; a_iv = 1'b1; a_rv = 1'b1;
        hs0 = a_hs;
        step();
        check("bp_first_valid", a_ov, 1);
        check("bp_first_sh", a_sh, 8'hB4);
        a_data = 4'b0101; a_rnd = 4'b1001;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp%0d_in_ready", c), a_ir, 0);
            check($sformatf("bp%0d_rnd_ready", c), a_rr, 0);
            step();
            check($sformatf("bp%0d_sh", c), a_sh, 8'hB4);
            check($sformatf("bp%0d_valid", c), a_ov, 1);
        end
        check("bp_rnd_handshakes", a_hs - hs0, 1);
        a_iv = 1'b0; a_rv = 1'b0; a_or = 1'b1;
        step();
        check("bp_drained", a_ov, 0);

        // Mismatched valids
        a_data = 4'b0011; a_rnd = 4'b0101; a_iv = 1'b1; a_rv = 1'b0;
        hs0 = a_hs;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("mm%0d_in_ready", c), a_ir, 0);
            check($sformatf("mm%0d_rnd_ready", c), a_rr, 1);
            step();
            check($sformatf("mm%0d_no_xfer", c), a_ov, 0);
        end
        a_rv = 1'b1;
        step();
        check("mm_encode_valid", a_ov, 1);
        check("mm_encode_sh", a_sh, ref_a(4'b0011, 4'b0101));
        a_iv = 1'b0; a_rv = 1'b0;
        step();
        check("mm_one_encode", a_hs - hs0, 1);

        // Streaming: 16 random back-to-back transfers
        a_or = 1'b1;
        for (int c = 0; c < 16; c++) begin
            a_data = 4'($urandom); a_rnd = 4'($urandom);
            a_iv = 1'b1; a_rv = 1'b1;
            exp_sh = ref_a(a_data, a_rnd);
            step();
            check($sformatf("st%0d_valid", c), a_ov, 1);
            check($sformatf("st%0d_sh", c), a_sh, exp_sh);
        end

        // Asynchronous reset between edges while holding a sharing
        a_iv = 1'b0; a_rv = 1'b0; a_or = 1'b0;
        held = a_sh;
        #3;
        check("pre_rst_valid", a_ov, 1);
        rst_n = 1'b0;
        a_iv = 1'b1; a_rv = 1'b1;
        #1;
        check("arst_valid", a_ov, 0);
        check("arst_sh", a_sh, 0);
        check("arst_in_ready", a_ir, 0);
        check("arst_rnd_ready", a_rr, 0);
        step();
        check("arst_held", a_ov, 0);
        a_data = 4'b1100; a_rnd = 4'b1010; a_or = 1'b1;
        #2 rst_n = 1'b1;
        step();
        check("post_rst_valid", a_ov, 1);
        check("post_rst_sh", a_sh, ref_a(4'b1100, 4'b1010));
        a_iv = 1'b0; a_rv = 1'b0;
        step();

        // d=3, count=1: random pairs, XOR of shares must recover the data
        b_or = 1'b1;
        for (int c = 0; c < 100; c++) begin
            b_data = 1'($urandom); b_rnd = 2'($urandom);
            b_iv = 1'b1; b_rv = 1'b1;
            step();
            check($sformatf("d3_%0d_valid", c), b_ov, 1);
            check($sformatf("d3_%0d_xor", c), ^b_sh, b_data);
            check($sformatf("d3_%0d_rnd", c), b_sh[1:0], b_rnd);
        end
        b_iv = 1'b0; b_rv = 1'b0;
        step();
        check("d3_drain", b_ov, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
